// File: rtl/sram_arbiter_pkg.sv
// rtl/sram_arbiter_pkg.sv - shared word width, line default, FSM states and RAM-select bit for the SRAM arbiter
package sram_arbiter_pkg;

  localparam int WORD             = 32;
  localparam int CACHE_LINE_WORDS = 4;
  localparam int RAM_SEL_BIT      = 22;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_RD   = 2'd1,
    ARB_WR   = 2'd2,
    ARB_DONE = 2'd3
  } arb_state_e;

  typedef enum logic {
    PORT_I = 1'b0,
    PORT_D = 1'b1
  } port_e;

endpackage

// File: rtl/sram_arbiter_if.sv
// rtl/sram_arbiter_if.sv - ICache/DCache request ports of the SRAM arbiter
interface sram_arbiter_if
  import sram_arbiter_pkg::*;
#(
  parameter int LINE_WORDS = CACHE_LINE_WORDS
) ();

  logic                         i_valid;
  logic [31:0]                  i_addr;
  logic                         i_abort;
  logic                         i_ready;
  logic [WORD*LINE_WORDS-1:0]   i_line;

  logic                         d_valid;
  logic                         d_store;
  logic [31:0]                  d_addr;
  logic [31:0]                  d_wdata;
  logic                         d_ready;
  logic [WORD*LINE_WORDS-1:0]   d_line;

  modport master (
    output i_valid, i_addr, i_abort, d_valid, d_store, d_addr, d_wdata,
    input  i_ready, i_line, d_ready, d_line
  );

  modport slave (
    input  i_valid, i_addr, i_abort, d_valid, d_store, d_addr, d_wdata,
    output i_ready, i_line, d_ready, d_line
  );

endinterface

// File: rtl/sram_arbiter_port_drv.sv
// rtl/sram_arbiter_port_drv.sv - per-SRAM strobe/address/data muxing; idle pins park at strobes high, addr/data 0
module sram_port_drv
  import sram_arbiter_pkg::*;
(
  input  logic            en,
  input  logic            rd,
  input  logic            wr,
  input  logic            we_low,
  input  logic [19:0]     word_addr,
  input  logic [WORD-1:0] wdata,
  output logic            ce_n,
  output logic            oe_n,
  output logic            we_n,
  output logic [19:0]     addr,
  output logic [WORD-1:0] wdata_out,
  output logic            drive
);

  logic active;

  assign active    = en && (rd || wr);
  assign ce_n      = !active;
  assign oe_n      = !(en && rd);
  assign we_n      = !(en && wr && we_low);
  assign drive     = en && wr;
  assign addr      = active ? word_addr : '0;
  assign wdata_out = (en && wr) ? wdata : '0;

endmodule

// File: rtl/sram_arbiter.sv
// rtl/sram_arbiter.sv - shares base/ext SRAM between ICache line fills and DCache fills/stores
// Define SRAM_ARB_RR_EN for round-robin arbitration; default is fixed DCache priority.
module sram_arbiter
  import sram_arbiter_pkg::*;
#(
  parameter int LINE_WORDS  = CACHE_LINE_WORDS,
  parameter int WAIT_CYCLES = 1
) (
  input  logic            clk,
  input  logic            rst,
  sram_arbiter_if.slave   bus,
  output logic            base_ram_ce_n,
  output logic            base_ram_oe_n,
  output logic            base_ram_we_n,
  output logic [19:0]     base_ram_addr,
  output logic [WORD-1:0] base_ram_wdata,
  output logic            base_ram_drive,
  input  logic [WORD-1:0] base_ram_rdata,
  output logic            ext_ram_ce_n,
  output logic            ext_ram_oe_n,
  output logic            ext_ram_we_n,
  output logic [19:0]     ext_ram_addr,
  output logic [WORD-1:0] ext_ram_wdata,
  output logic            ext_ram_drive,
  input  logic [WORD-1:0] ext_ram_rdata
);

  localparam int WCW = (LINE_WORDS > 1) ? $clog2(LINE_WORDS) : 1;
  localparam int WTW = $clog2(WAIT_CYCLES + 1);

  arb_state_e                 state_q, state_d;
  port_e                      gnt_q;
  logic                       ext_q, abort_q;
  logic [19:0]                addr_q;
  logic [WORD-1:0]            wdata_q;
  logic [WCW-1:0]             wc_q;
  logic [WTW-1:0]             wt_q;
  logic [WORD*LINE_WORDS-1:0] line_q, line_next;
  logic [31:0]                req_addr;
  logic [WORD-1:0]            rdata_sel;
  logic                       pick_d, req, last_wait, word_last, abort_now;
  logic                       rd_act, wr_act, we_low;
  logic                       unused_addr_bits;

`ifdef SRAM_ARB_RR_EN
  port_e last_grant_q;
  assign pick_d = bus.d_valid && (!bus.i_valid || last_grant_q == PORT_I);
`else
  assign pick_d = bus.d_valid;
`endif

  assign req       = bus.i_valid || bus.d_valid;
  assign req_addr  = pick_d ? bus.d_addr : bus.i_addr;
  assign last_wait = (wt_q == WTW'(WAIT_CYCLES - 1));
  assign word_last = (wc_q == WCW'(LINE_WORDS - 1));
  assign abort_now = abort_q || (bus.i_abort && gnt_q == PORT_I);
  assign rdata_sel = ext_q ? ext_ram_rdata : base_ram_rdata;
  assign rd_act    = (state_q == ARB_RD);
  assign wr_act    = (state_q == ARB_WR);
  assign we_low    = (wt_q < WTW'(WAIT_CYCLES));
  assign unused_addr_bits = ^{bus.i_addr[31:23], bus.i_addr[1:0], bus.d_addr[31:23], bus.d_addr[1:0]};

  assign bus.i_ready = (state_q == ARB_DONE) && (gnt_q == PORT_I);
  assign bus.d_ready = (state_q == ARB_DONE) && (gnt_q == PORT_D);

  always_comb begin
    state_d   = state_q;
    line_next = line_q;
    line_next[int'(wc_q)*WORD +: WORD] = rdata_sel;
    case (state_q)
      ARB_IDLE: if (req) state_d = (pick_d && bus.d_store) ? ARB_WR : ARB_RD;
      ARB_RD: begin
        // An abort only takes effect at the end of a word's strobe window.
        if (last_wait) begin
          if (abort_now)      state_d = ARB_IDLE;
          else if (word_last) state_d = ARB_DONE;
        end
      end
      ARB_WR:   if (wt_q == WTW'(WAIT_CYCLES)) state_d = ARB_DONE;
      ARB_DONE: state_d = ARB_IDLE;
      default:  state_d = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= ARB_IDLE;
      gnt_q      <= PORT_I;
      ext_q      <= 1'b0;
      abort_q    <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      wc_q       <= '0;
      wt_q       <= '0;
      line_q     <= '0;
      bus.i_line <= '0;
      bus.d_line <= '0;
`ifdef SRAM_ARB_RR_EN
      last_grant_q <= PORT_I;
`endif
    end else begin
      state_q <= state_d;
      case (state_q)
        ARB_IDLE: if (req) begin
          gnt_q   <= pick_d ? PORT_D : PORT_I;
          ext_q   <= req_addr[RAM_SEL_BIT];
          // Fills start at the line's first word; stores keep the exact word.
          addr_q  <= (pick_d && bus.d_store) ? req_addr[21:2]
                                             : (req_addr[21:2] & ~20'(LINE_WORDS - 1));
          wdata_q <= bus.d_wdata;
          wc_q    <= '0;
          wt_q    <= '0;
          abort_q <= 1'b0;
`ifdef SRAM_ARB_RR_EN
          last_grant_q <= pick_d ? PORT_D : PORT_I;
`endif
        end
        ARB_RD: begin
          if (bus.i_abort && gnt_q == PORT_I) abort_q <= 1'b1;
          if (last_wait) begin
            wt_q   <= '0;
            wc_q   <= word_last ? '0 : wc_q + WCW'(1);
            line_q <= line_next;
            if (word_last && !abort_now) begin
              if (gnt_q == PORT_D) bus.d_line <= line_next;
              else                 bus.i_line <= line_next;
            end
          end else begin
            wt_q <= wt_q + WTW'(1);
          end
        end
        ARB_WR:   wt_q <= wt_q + WTW'(1);
        default:  abort_q <= 1'b0;
      endcase
    end
  end

  sram_port_drv u_base (
    .en(!ext_q), .rd(rd_act), .wr(wr_act), .we_low(we_low),
    .word_addr(addr_q + 20'(wc_q)), .wdata(wdata_q),
    .ce_n(base_ram_ce_n), .oe_n(base_ram_oe_n), .we_n(base_ram_we_n),
    .addr(base_ram_addr), .wdata_out(base_ram_wdata), .drive(base_ram_drive)
  );

  sram_port_drv u_ext (
    .en(ext_q), .rd(rd_act), .wr(wr_act), .we_low(we_low),
    .word_addr(addr_q + 20'(wc_q)), .wdata(wdata_q),
    .ce_n(ext_ram_ce_n), .oe_n(ext_ram_oe_n), .we_n(ext_ram_we_n),
    .addr(ext_ram_addr), .wdata_out(ext_ram_wdata), .drive(ext_ram_drive)
  );

endmodule
